// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: opcodes, command field
// layout, sequencer state encoding and the divide-by-zero trap value.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    // Packed command {op[2:0], a[3:0], b[3:0]}
    localparam int CMD_W = 11;
    localparam int OP_HI = 10;
    localparam int OP_LO = 8;
    localparam int A_HI  = 7;
    localparam int A_LO  = 4;
    localparam int B_HI  = 3;
    localparam int B_LO  = 0;

    localparam logic [7:0] DIV0_RESULT = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

    // The only field inspection the sequencer ever does.
    function automatic logic is_div0(input logic [CMD_W-1:0] cmd);
        return (cmd[OP_HI:OP_LO] == OP_DIV) && (cmd[B_HI:B_LO] == 4'd0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small synchronous command FIFO. The head entry is read combinationally
// because the sequencer inspects it in the same cycle it decides to pop.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic [AW:0]   level_next;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Storage write at the tail; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Occupancy update: simultaneous push and pop leave it unchanged.
    always_comb begin
        level_next = level_reg;
        case ({push_ok, pop_ok})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg <= level_next;
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign full  = (level_reg == (AW+1)'(DEPTH));
    assign empty = (level_reg == '0);
    assign level = level_reg;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds queued commands to the ALU one at a time, waits the ALU latency,
// and returns each result on a valid/ready response port. Divide-by-zero
// is answered locally without touching the ALU lines.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [CMD_W-1:0]         cmd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_result,
    output logic [2:0]               rsp_op,
    output logic                     rsp_err,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    output logic [2:0]               alu_op,
    input  logic [7:0]               alu_result,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy
);

    localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 1);

    logic [CMD_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    seq_state_t state_reg, state_next;
    logic [2:0] cnt_reg,   cnt_next;
    logic [3:0] a_reg,     a_next;
    logic [3:0] b_reg,     b_next;
    logic [2:0] op_reg,    op_next;
    logic [7:0] res_reg,   res_next;
    logic [2:0] rop_reg,   rop_next;
    logic       err_reg,   err_next;

    assign push = cmd_valid & ~fifo_full;
    assign pop  = (state_reg == ST_IDLE) & ~fifo_empty;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (cmd_data),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Next-state and register updates for issue, wait and respond.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        res_next   = res_reg;
        rop_next   = rop_reg;
        err_next   = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (is_div0(head)) begin
                        // ALU lines keep the previous command.
                        res_next   = DIV0_RESULT;
                        rop_next   = OP_DIV;
                        err_next   = 1'b1;
                        state_next = ST_RESP;
                    end else begin
                        a_next     = head[A_HI:A_LO];
                        b_next     = head[B_HI:B_LO];
                        op_next    = head[OP_HI:OP_LO];
                        cnt_next   = LAT_M1;
                        state_next = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_reg != 3'd0) begin
                    cnt_next = cnt_reg - 3'd1;
                end else begin
                    res_next   = alu_result;
                    rop_next   = op_reg;
                    err_next   = 1'b0;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            res_reg   <= '0;
            rop_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_next;
            res_reg   <= res_next;
            rop_reg   <= rop_next;
            err_reg   <= err_next;
        end
    end

    assign cmd_ready  = ~fifo_full;
    assign rsp_valid  = (state_reg == ST_RESP);
    assign busy       = (state_reg != ST_IDLE);
    assign rsp_result = res_reg;
    assign rsp_op     = rop_reg;
    assign rsp_err    = err_reg;
    assign alu_a      = a_reg;
    assign alu_b      = b_reg;
    assign alu_op     = op_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a behavioural ALU, a response scoreboard
// checked every cycle, and directed scenarios with literal expectations.
module tb_alu_cmd_sequencer;

    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_result;
    logic [2:0]  fifo_level;
    logic        busy;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 4-bit ALU with 8-bit result.
    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] ea, eb;
        ea = {4'h0, a};
        eb = {4'h0, b};
        case (op)
            3'b000:  return ea + eb;
            3'b001:  return ea - eb;
            3'b010:  return ea & eb;
            3'b011:  return ea | eb;
            3'b100:  return ea ^ eb;
            3'b101:  return {4'h0, ~a};
            3'b110:  return ea * eb;
            default: return (b == 4'd0) ? 8'h00 : ea / eb;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_op, alu_a, alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted command yields exactly one response, in order.
    typedef struct {
        logic [7:0] res;
        logic [2:0] op;
        logic       err;
        logic [3:0] a;
        logic [3:0] b;
    } exp_t;

    exp_t       expq[$];
    int         outstanding = 0;
    int         resp_count = 0;
    logic [3:0] last_a, last_b;
    logic [2:0] last_op;

    // Per-cycle compare, sampled mid-cycle ahead of the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        exp_t n;
        if (rst) begin
            expq.delete();
            outstanding = 0;
            last_a  = 4'h0;
            last_b  = 4'h0;
            last_op = 3'h0;
        end else begin
            check("occupancy", int'(fifo_level) + int'(busy), outstanding);
            check("cmd_ready_vs_level", cmd_ready, fifo_level != 3'(DEPTH));
            check("no_div0_on_alu", (alu_op == 3'b111) && (alu_b == 4'h0), 1'b0);
            if (expq.size() == 0) begin
                check("spurious_rsp", rsp_valid, 1'b0);
            end else if (rsp_valid) begin
                e = expq[0];
                check("rsp_result", rsp_result, e.res);
                check("rsp_op", rsp_op, e.op);
                check("rsp_err", rsp_err, e.err);
                if (e.err) begin
                    check("alu_held_on_trap", {alu_op, alu_a, alu_b}, {last_op, last_a, last_b});
                end else begin
                    check("alu_ports", {alu_op, alu_a, alu_b}, {e.op, e.a, e.b});
                end
                if (rsp_ready) begin
                    $display("RSP #%0d op=%0d result=%02h err=%0d", resp_count, rsp_op, rsp_result, rsp_err);
                    if (!e.err) begin
                        last_a  = e.a;
                        last_b  = e.b;
                        last_op = e.op;
                    end
                    void'(expq.pop_front());
                    outstanding--;
                    resp_count++;
                end
            end
            if (cmd_valid && cmd_ready) begin
                n.op  = cmd_data[10:8];
                n.a   = cmd_data[7:4];
                n.b   = cmd_data[3:0];
                n.err = (n.op == 3'b111) && (n.b == 4'h0);
                n.res = n.err ? 8'h00 : alu_fn(n.op, n.a, n.b);
                expq.push_back(n);
                outstanding++;
            end
        end
    end

    // Offer one command; returns the cycle index of its handshake edge.
    task automatic push_cmd(input logic [10:0] d, output int n);
        int t;
        t = 0;
        cmd_valid = 1'b1;
        cmd_data  = d;
        @(negedge clk);
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) check("push_timeout", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        n = cyc;
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid; returns the cycle index at that point.
    task automatic wait_rsp(output int c);
        int t;
        t = 0;
        @(negedge clk);
        while (!rsp_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rsp_valid) check("rsp_timeout", rsp_valid, 1'b1);
        c = cyc;
    endtask

    task automatic do_single(input string name, input logic [10:0] d, input int exp_lat,
                             input logic [7:0] exp_res, input logic exp_err);
        int n, c;
        push_cmd(d, n);
        wait_rsp(c);
        check({name, "_latency"}, c - n + 1, exp_lat);
        check({name, "_result"}, rsp_result, exp_res);
        check({name, "_op"}, rsp_op, d[10:8]);
        check({name, "_err"}, rsp_err, exp_err);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    logic [10:0] bp_cmds [6];
    logic [7:0]  bp_res  [5];

    initial begin
        int n, c, c1, c2, acc, maxl, t, base;
        logic last_ready;
        logic [2:0] op;
        logic [3:0] a, b;

        bp_cmds[0] = {3'b000, 4'h5, 4'h3};
        bp_cmds[1] = {3'b001, 4'h9, 4'h2};
        bp_cmds[2] = {3'b010, 4'hF, 4'h3};
        bp_cmds[3] = {3'b011, 4'h8, 4'h1};
        bp_cmds[4] = {3'b100, 4'hF, 4'h5};
        bp_cmds[5] = {3'b101, 4'h6, 4'h0};
        bp_res[0] = 8'h08;
        bp_res[1] = 8'h07;
        bp_res[2] = 8'h03;
        bp_res[3] = 8'h09;
        bp_res[4] = 8'h0A;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_data = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_level", fifo_level, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp", {rsp_result, rsp_op, rsp_err}, 12'h000);
        check("rst_alu", {alu_op, alu_a, alu_b}, 11'h000);

        // ADD 1+2: ports during EXEC, then response
        push_cmd({3'b000, 4'h1, 4'h2}, n);
        @(negedge clk);
        @(negedge clk);
        check("add_exec_busy", busy, 1'b1);
        check("add_exec_alu_a", alu_a, 4'h1);
        check("add_exec_alu_b", alu_b, 4'h2);
        check("add_exec_alu_op", alu_op, 3'b000);
        wait_rsp(c);
        check("add_latency", c - n + 1, ALU_LAT + 2);
        check("add_result", rsp_result, 8'h03);
        check("add_op", rsp_op, 3'b000);
        check("add_err", rsp_err, 1'b0);
        @(posedge clk);
        #1;

        // SUB then MUL back to back
        push_cmd({3'b001, 4'h4, 4'h3}, n);
        push_cmd({3'b110, 4'h3, 4'h2}, n);
        wait_rsp(c1);
        check("sub_result", rsp_result, 8'h01);
        @(posedge clk);
        #1;
        wait_rsp(c2);
        check("mul_result", rsp_result, 8'h06);
        check("b2b_spacing", c2 - c1, ALU_LAT + 2);
        @(posedge clk);
        #1;

        // Divide by zero trapped
        do_single("div0", {3'b111, 4'h9, 4'h0}, 2, 8'h00, 1'b1);
        check("div0_alu_held", {alu_op, alu_a, alu_b}, {3'b110, 4'h3, 4'h2});
        // Non-zero divide goes to the ALU normally
        do_single("div", {3'b111, 4'h9, 4'h2}, ALU_LAT + 2, 8'h04, 1'b0);

        // Back-pressure: six offered, five accepted
        rsp_ready = 1'b0;
        acc = 0;
        maxl = 0;
        last_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = bp_cmds[i];
            @(negedge clk);
            last_ready = cmd_ready;
            if (cmd_ready) acc++;
            if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check("bp_accepted", acc, 5);
        check("bp_max_level", maxl, DEPTH);
        check("bp_6th_ready", last_ready, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("bp_hold_valid", rsp_valid, 1'b1);
        check("bp_hold_result", rsp_result, 8'h08);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(c);
            check("bp_drain_result", rsp_result, bp_res[i]);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("bp_ready_back", cmd_ready, 1'b1);
        check("bp_level_empty", fifo_level, 3'd0);
        @(posedge clk);
        #1;

        // Simultaneous push and pop at level 2
        rsp_ready = 1'b0;
        push_cmd({3'b000, 4'h1, 4'h1}, n);
        push_cmd({3'b110, 4'h2, 4'h3}, n);
        push_cmd({3'b000, 4'h4, 4'h4}, n);
        wait_rsp(c);
        check("pp_level_before", fifo_level, 3'd2);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = {3'b000, 4'h7, 4'h7};
        check("pp_level_idle", fifo_level, 3'd2);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("pp_level_after", fifo_level, 3'd2);
        check("pp_busy", busy, 1'b1);
        rsp_ready = 1'b1;
        wait_rsp(c);
        check("pp_r1", rsp_result, 8'h06);
        @(posedge clk);
        #1;
        wait_rsp(c);
        check("pp_r2", rsp_result, 8'h08);
        @(posedge clk);
        #1;
        wait_rsp(c);
        check("pp_r3", rsp_result, 8'h0E);
        @(posedge clk);
        #1;

        // Pointer wrap: 3*DEPTH commands under varying back-pressure
        base = resp_count;
        fork
            begin
                for (int i = 0; i < 3 * DEPTH; i++) begin
                    op = 3'(i % 8);
                    a  = 4'((i * 3 + 1) % 16);
                    b  = (i == 7) ? 4'h0 : 4'((i + 1) % 6);
                    push_cmd({op, a, b}, n);
                end
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    rsp_ready = (k % 3 != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        rsp_ready = 1'b1;
        t = 0;
        while (outstanding != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("wrap_drained", outstanding, 0);
        check("wrap_count", resp_count - base, 3 * DEPTH);

        // Reset during EXEC with three queued
        rsp_ready = 1'b0;
        push_cmd({3'b000, 4'h2, 4'h3}, n);
        push_cmd({3'b000, 4'h3, 4'h3}, n);
        push_cmd({3'b001, 4'h8, 4'h3}, n);
        push_cmd({3'b010, 4'h7, 4'h3}, n);
        wait_rsp(c);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = {3'b011, 4'h1, 4'h4};
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("mid_level", fifo_level, 3'd3);
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_level", fifo_level, 3'd0);
        check("mrst_rsp_valid", rsp_valid, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_alu", {alu_op, alu_a, alu_b}, 11'h000);
        check("mrst_cmd_ready", cmd_ready, 1'b1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("mrst_no_stale", rsp_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        do_single("post_rst_add", {3'b000, 4'h2, 4'h2}, ALU_LAT + 2, 8'h04, 1'b0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream stage of the 4-bit ALU.
- Accepts packed ALU commands over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU operand and opcode lines one command at a time and waits a fixed ALU latency.
- Captures the 8-bit result and returns it on a valid/ready response port. Divide-by-zero is trapped locally and never issued to the ALU.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, 2..16.
ALU_LAT, 1, cycles the ALU result is sampled after operands are driven; 1..7.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
cmd_valid  in  1  command present.
cmd_ready  out  1  FIFO can accept; equals !full.
cmd_data  in  11  {op[2:0], a[3:0], b[3:0]}; a/b use the same nibble order as the ALU's ui_in.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts response.
rsp_result  out  8  ALU result.
rsp_op  out  3  echo of executed opcode.
rsp_err  out  1  1 = divide-by-zero trapped.
alu_a  out  4  operand A to ALU.
alu_b  out  4  operand B to ALU.
alu_op  out  3  opcode to ALU.
alu_result  in  8  ALU output.
fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.
busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst=1 at an edge) is synchronous, clears everything:
  - FIFO empty, fifo_level=0, cmd_ready=1.
  - FSM=IDLE, busy=0.
  - rsp_valid=0, rsp_result=0, rsp_op=0, rsp_err=0.
  - alu_a/alu_b/alu_op=0; exec counter=0.
- Reset mid-operation discards in-flight and queued commands; no response is produced for them.
- Push: cmd_valid & cmd_ready at an edge writes cmd_data at the tail.
  - A push while full is impossible, because cmd_ready=0.
- Pop: occurs only from IDLE when the FIFO is non-empty.
  - A push and a pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, EXEC, RESP.
  - IDLE, FIFO non-empty, op=3'b111 and b=0: pop, go to RESP.
    - rsp_result=8'h00, rsp_err=1, rsp_op=3'b111.
    - alu_* registers unchanged.
  - IDLE, FIFO non-empty, otherwise: pop, load alu_a/alu_b/alu_op from the head, counter=ALU_LAT-1, go to EXEC.
  - EXEC, counter≠0: decrement counter.
  - EXEC, counter=0: capture rsp_result=alu_result, rsp_op=alu_op, rsp_err=0; go to RESP.
  - RESP: rsp_valid=1. When rsp_ready=1, go to IDLE next cycle.
    - rsp_result, rsp_op and rsp_err are held stable while rsp_valid=1 and rsp_ready=0.
- alu_a/alu_b/alu_op hold the last issued values outside EXEC.
- Latency: handshake at cycle N with FIFO empty and FSM idle gives a result as follows.
  - Normal command: rsp_valid high at cycle N+2+ALU_LAT.
  - Trapped command: rsp_valid high at cycle N+2.
- Throughput:
  - Normal command: one per ALU_LAT+2 cycles with rsp_ready tied high.
  - Trapped command: one per 2 cycles.
- busy=1 in EXEC and RESP.
- Opcode encoding (fixed by the ALU): 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 MUL, 111 DIV.
  - The sequencer never interprets results.
  - Only the DIV-by-zero check inspects fields.
- Total capacity under back-pressure is DEPTH+1 commands: DEPTH queued plus one in the FSM.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD..OP_DIV;
  - CMD_W=11 and field slice positions;
  - FSM state encoding (IDLE/EXEC/RESP);
  - DIV0_RESULT=8'h00.
- One sub-module: alu_cmd_fifo.
  - Parameterised synchronous FIFO with push/pop/full/empty/level, same clk/rst.
  - The FSM and response registers stay in alu_cmd_sequencer.

Test Plan:
- Reset, then ADD: cmd_data={000,0001,0010}, ALU model returns a+b -> alu_a=1, alu_b=2, alu_op=000 in EXEC; rsp_valid at N+3 with rsp_result=8'h03, rsp_op=000, rsp_err=0.
- Back-to-back SUB {001,0100,0011} then MUL {110,0011,0010}, rsp_ready=1 -> responses in order: 8'h01 then 8'h06, spaced ALU_LAT+2 cycles; ALU port values match each command.
- DIV by zero {111,1001,0000} -> rsp_valid at N+2, rsp_result=8'h00, rsp_err=1; alu_op keeps the prior value and is never driven to 111 with b=0.
- Back-pressure: rsp_ready=0, push 6 commands -> first five accepted, fifo_level reaches 4, cmd_ready=0 on the 6th; rsp_result is held stable; release rsp_ready -> all five responses in order and cmd_ready returns to 1.
- Simultaneous push/pop with level=2 -> level stays 2; pointer wrap verified over 3×DEPTH commands with no loss or reorder.
- Reset asserted during EXEC with 3 queued -> next cycle fifo_level=0, rsp_valid=0, busy=0, alu_* = 0; no stale response appears afterwards.
